// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between IF fetch and MEM-stage
// data access; MEM stage wins ties unless IF has waited STARVE_MAX consecutive DM grants.
module mem_port_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_data_o,
   output logic              if_ack_o,
   output logic              if_stall_o,
   input  logic [1:0]        dm_row_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_ack_o,
   output logic              dm_stall_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [SW-1:0]   r_starve;
   logic            r_own_dm;
   logic            w_dm_wr;
   logic            w_dm_req;
   logic            w_grant_dm;
   assign w_dm_wr    = (dm_row_i == 2'b10);
   assign w_dm_req   = (dm_row_i == 2'b01) | w_dm_wr;
   assign w_grant_dm = w_dm_req & (~if_req_i | (r_starve != SMAX));
   assign if_stall_o = if_req_i & ~if_ack_o;
   assign dm_stall_o = w_dm_req & ~dm_ack_o;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_starve    <= '0;
         r_own_dm    <= 1'b0;
         if_data_o   <= '0;
         if_ack_o    <= 1'b0;
         dm_rdata_o  <= '0;
         dm_ack_o    <= 1'b0;
         mem_en_o    <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
      end else begin
         mem_en_o <= 1'b0;
         if_ack_o <= 1'b0;
         dm_ack_o <= 1'b0;
         case (r_state)
            S_IDLE: if (w_dm_req | if_req_i) begin
               r_state     <= S_ACCESS;
               mem_en_o    <= 1'b1;
               r_own_dm    <= w_grant_dm;
               mem_addr_o  <= w_grant_dm ? dm_addr_i : if_addr_i;
               mem_we_o    <= w_grant_dm & w_dm_wr;
               mem_wdata_o <= w_grant_dm ? dm_wdata_i : '0;
               r_cnt       <= CW'(MEM_LAT - 1);
               // a DM win over a waiting IF counts toward the guard; anything else clears it
               r_starve    <= (w_grant_dm & if_req_i) ? ((r_starve == SMAX) ? r_starve : r_starve + SW'(1)) : '0;
            end
            S_ACCESS: if (r_cnt == '0) begin
               r_state <= S_RESP;
               if (!mem_we_o && r_own_dm) dm_rdata_o <= mem_rdata_i;
               if (!mem_we_o && !r_own_dm) if_data_o <= mem_rdata_i;
               if_ack_o <= ~r_own_dm;
               dm_ack_o <= r_own_dm;
            end else begin
               r_cnt <= r_cnt - CW'(1);
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus against a transaction-timeline model of the arbiter,
// with a registered memory model returning data one cycle after the access strobe.
module tb_mem_port_arbiter;
   localparam int LAT  = 2;
   localparam int SMAX = 4;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        if_req_i = 1'b0;
   logic [11:0] if_addr_i = '0;
   logic [31:0] if_data_o;
   logic        if_ack_o;
   logic        if_stall_o;
   logic [1:0]  dm_row_i = 2'b00;
   logic [11:0] dm_addr_i = '0;
   logic [31:0] dm_wdata_i = '0;
   logic [31:0] dm_rdata_o;
   logic        dm_ack_o;
   logic        dm_stall_o;
   logic        mem_en_o;
   logic        mem_we_o;
   logic [11:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
      .if_ack_o(if_ack_o), .if_stall_o(if_stall_o),
      .dm_row_i(dm_row_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o), .dm_stall_o(dm_stall_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [11:0] a);
      return (a == 12'h010) ? 32'hDEADBEEF : (32'hA500_0000 ^ {20'h0, a});
   endfunction

   // memory environment: registered read data, garbage while the strobe is high
   logic [31:0] mem_arr [4096];
   bit          mem_wr  [4096];
   logic [31:0] rd_reg = '0;
   assign mem_rdata_i = mem_en_o ? 32'hBAD0BAD0 : rd_reg;
   always @(posedge clk_i) begin
      if (mem_en_o) begin
         rd_reg <= mem_wr[mem_addr_o] ? mem_arr[mem_addr_o] : init_word(mem_addr_o);
         if (mem_we_o) begin
            mem_arr[mem_addr_o] <= mem_wdata_o;
            mem_wr[mem_addr_o]  <= 1'b1;
         end
      end
   end

   // timeline model: a grant in cycle g strobes at g+1, acks at g+1+LAT, frees at g+2+LAT
   logic [31:0] model_mem [4096];
   bit          model_wr  [4096];
   int          m_free = 0, m_en_c = -10, m_ack_c = -10, m_starve = 0;
   bit          m_own_dm = 0, m_we = 0, m_pend_rd = 0;
   logic [11:0] m_addr = '0;
   logic [31:0] m_wdata = '0, m_pend = '0, m_if_data = '0, m_dm_data = '0;
   logic        t_dreq, t_dwin, t_we;
   logic [11:0] t_addr;
   assign t_dreq = (dm_row_i == 2'b01) || (dm_row_i == 2'b10);
   assign t_dwin = t_dreq && !(if_req_i && m_starve == SMAX);
   assign t_addr = t_dwin ? dm_addr_i : if_addr_i;
   assign t_we   = t_dwin && (dm_row_i == 2'b10);
   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (rst_i) begin
         m_free <= 0; m_en_c <= -10; m_ack_c <= -10; m_starve <= 0;
         m_if_data <= '0; m_dm_data <= '0;
      end else begin
         if (cyc == m_ack_c - 1 && m_pend_rd) begin
            if (m_own_dm) m_dm_data <= m_pend;
            else m_if_data <= m_pend;
         end
         if (cyc >= m_free && (t_dreq || if_req_i)) begin
            m_starve  <= (t_dwin && if_req_i) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
            m_own_dm  <= t_dwin;
            m_addr    <= t_addr;
            m_we      <= t_we;
            m_wdata   <= dm_wdata_i;
            m_pend    <= model_wr[t_addr] ? model_mem[t_addr] : init_word(t_addr);
            m_pend_rd <= !t_we;
            if (t_we) begin
               model_mem[t_addr] <= dm_wdata_i;
               model_wr[t_addr]  <= 1'b1;
            end
            m_en_c  <= cyc + 1;
            m_ack_c <= cyc + 1 + LAT;
            m_free  <= cyc + 2 + LAT;
         end
      end
   end

   int          en_cyc = -1;
   logic [11:0] en_addr = '0;
   logic        en_we = 1'b0;
   logic [31:0] en_wdata = '0;
   always @(posedge clk_i) begin
      #2;
      if (!rst_i) begin
         chk("mem_en", 32'(mem_en_o), 32'(cyc == m_en_c));
         chk("if_ack", 32'(if_ack_o), 32'(cyc == m_ack_c && !m_own_dm));
         chk("dm_ack", 32'(dm_ack_o), 32'(cyc == m_ack_c && m_own_dm));
         if (cyc >= m_en_c && cyc < m_ack_c) begin
            chk("mem_addr", 32'(mem_addr_o), 32'(m_addr));
            chk("mem_we", 32'(mem_we_o), 32'(m_we));
            if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
         end
         chk("if_data", if_data_o, m_if_data);
         chk("dm_rdata", dm_rdata_o, m_dm_data);
         chk("if_stall", 32'(if_stall_o), 32'(if_req_i && !(cyc == m_ack_c && !m_own_dm)));
         chk("dm_stall", 32'(dm_stall_o), 32'(t_dreq && !(cyc == m_ack_c && m_own_dm)));
      end
      if (mem_en_o) begin
         en_cyc = cyc; en_addr = mem_addr_o; en_we = mem_we_o; en_wdata = mem_wdata_o;
      end
   end

   task automatic single(input bit use_if, input logic [1:0] row, input logic [11:0] a,
                         input logic [31:0] wd, output int k_ack);
      k_ack = -1;
      if (use_if) begin
         if_req_i = 1'b1; if_addr_i = a;
      end else begin
         dm_row_i = row; dm_addr_i = a; dm_wdata_i = wd;
      end
      for (int k = 0; k < 12 && k_ack < 0; k++) begin
         #1;
         if (if_ack_o || dm_ack_o) begin
            k_ack = k; if_req_i = 1'b0; dm_row_i = 2'b00;
         end
         @(negedge clk_i);
      end
      if_req_i = 1'b0; dm_row_i = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   int t, ka, n;
   bit seq [11];
   bit exp4 [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};

   initial begin
      #1 rst_i = 1'b1;
      #1;
      chk("rst_mem_en", 32'(mem_en_o), 0);
      chk("rst_ack", 32'({if_ack_o, dm_ack_o}), 0);
      chk("rst_addr", 32'(mem_addr_o), 0);
      chk("rst_data", if_data_o | dm_rdata_o, 0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      t = cyc;
      single(1'b1, 2'b00, 12'h010, 32'h0, ka);
      chk("t1_ack_lat", ka, 3);
      chk("t1_en_cyc", en_cyc, t + 1);
      chk("t1_en_addr", 32'(en_addr), 32'h010);
      chk("t1_en_we", 32'(en_we), 0);
      chk("t1_if_data", if_data_o, 32'hDEADBEEF);
      t = cyc;
      single(1'b0, 2'b10, 12'hFFF, 32'h12345678, ka);
      chk("t2_ack_lat", ka, 3);
      chk("t2_en_we", 32'(en_we), 1);
      chk("t2_en_wdata", en_wdata, 32'h12345678);
      chk("t2_dm_rdata", dm_rdata_o, 0);
      chk("t2_if_data", if_data_o, 32'hDEADBEEF);
      t = cyc;
      if_req_i = 1'b1; if_addr_i = 12'h020; dm_row_i = 2'b01; dm_addr_i = 12'hFFF;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("t3_if_stall", 32'(if_stall_o), 32'(k < 7));
         chk("t3_dm_ack", 32'(dm_ack_o), 32'(k == 3));
         chk("t3_if_ack", 32'(if_ack_o), 32'(k == 7));
         if (k == 5) begin
            chk("t3_if_en", 32'(mem_en_o), 1);
            chk("t3_if_addr", 32'(mem_addr_o), 32'h020);
         end
         if (dm_ack_o) dm_row_i = 2'b00;
         if (if_ack_o) if_req_i = 1'b0;
         @(negedge clk_i);
      end
      if_req_i = 1'b0; dm_row_i = 2'b00;
      chk("t3_dm_rdata", dm_rdata_o, 32'h12345678);
      chk("t3_if_data", if_data_o, 32'hA5000020);
      n = 0;
      dm_row_i = 2'b01; dm_addr_i = 12'h100; if_req_i = 1'b1; if_addr_i = 12'h030;
      for (int c = 0; c < 80 && n < 11; c++) begin
         #1;
         if (dm_ack_o) begin
            seq[n] = 1'b1; n++; dm_addr_i = dm_addr_i + 12'h1;
         end else if (if_ack_o) begin
            seq[n] = 1'b0; n++; if_addr_i = if_addr_i + 12'h1;
         end
         if (n == 11) begin
            dm_row_i = 2'b00; if_req_i = 1'b0;
         end
         @(negedge clk_i);
      end
      dm_row_i = 2'b00; if_req_i = 1'b0;
      chk("t4_grants", n, 11);
      for (int i = 0; i < 11; i++) chk($sformatf("t4_grant%0d", i), 32'(seq[i]), 32'(exp4[i]));
      t = cyc;
      if_req_i = 1'b1; if_addr_i = 12'h040;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      chk("t5_rst_addr", 32'(mem_addr_o), 0);
      chk("t5_rst_en_we", 32'({mem_en_o, mem_we_o}), 0);
      chk("t5_rst_data", if_data_o | dm_rdata_o | mem_wdata_o, 0);
      if_req_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("t5_no_ack", 32'({if_ack_o, dm_ack_o}), 0);
         @(negedge clk_i);
      end
      single(1'b0, 2'b01, 12'h010, 32'h0, ka);
      chk("t5_ack_lat", ka, 3);
      chk("t5_dm_rdata", dm_rdata_o, 32'hDEADBEEF);
      dm_row_i = 2'b11;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("t6_mem_en", 32'(mem_en_o), 0);
         chk("t6_dm_ack", 32'(dm_ack_o), 0);
         chk("t6_dm_stall", 32'(dm_stall_o), 0);
         @(negedge clk_i);
      end
      dm_row_i = 2'b00;
      repeat (2) @(negedge clk_i);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
